// File: rtl/cello_tt_eval_seq.sv
// Clocked truth-table evaluator: run-time loadable N_IN-input Boolean function
// with a programmable settle window and a saturating output-transition counter.
module cello_tt_eval_seq #(
  parameter int                    N_IN     = 4,
  parameter logic [(2**N_IN)-1:0]  RESET_TT = 16'hB8AD,
  parameter int                    SETTLE   = 2,
  parameter int                    CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_ready,
  output logic              cfg_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic [CNT_W-1:0]  toggle_cnt
);

  localparam int DEPTH = 2**N_IN;

  typedef enum logic [1:0] {RUN, SETTLE_WAIT, HOLD, LOAD} state_t;

  state_t            state;
  logic [DEPTH-1:0]  tt;
  logic [DEPTH-1:0]  shadow;
  logic [DEPTH-1:0]  shadow_next;
  logic [N_IN-1:0]   vec_q;
  logic [7:0]        settle_cnt;
  logic [N_IN:0]     load_cnt;
  logic              prev_bit;
  logic              armed;
  logic              in_fire;
  logic              out_fire;
  logic              cfg_fire;

  // armed keeps in_ready low while rst_n is asserted and for the first cycle after.
  // In HOLD the drain and the next accept share one edge, so in_ready follows out_ready.
  assign in_ready    = (state == RUN && armed) || (state == HOLD && out_ready);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign shadow_next = {shadow[DEPTH-2:0], cfg_bit};

  // NOTE: the shadow register has no reset; every bit is overwritten before a commit,
  // and an aborted load never reaches the active table.
  always_ff @(posedge clk) begin
    if (cfg_fire) shadow <= shadow_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      tt         <= RESET_TT;
      vec_q      <= '0;
      settle_cnt <= '0;
      load_cnt   <= '0;
      prev_bit   <= 1'b0;
      armed      <= 1'b0;
      out_valid  <= 1'b0;
      out_bit    <= 1'b0;
      cfg_ready  <= 1'b0;
      cfg_done   <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      armed    <= 1'b1;
      cfg_done <= 1'b0;

      // NOTE: later non-blocking assignments in this block override earlier ones,
      // so the drain clears out_valid and an SETTLE=0 accept may set it again.
      if (out_fire) begin
        if (out_bit != prev_bit && toggle_cnt != '1) toggle_cnt <= toggle_cnt + 1'b1;
        prev_bit  <= out_bit;
        out_valid <= 1'b0;
      end

      if (in_fire) begin
        vec_q      <= in_vec;
        settle_cnt <= 8'(SETTLE);
        if (SETTLE == 0) begin
          out_bit   <= tt[in_vec];
          out_valid <= 1'b1;
          state     <= HOLD;
        end else begin
          state     <= SETTLE_WAIT;
        end
      end

      case (state)
        RUN: begin
          if (!in_fire && cfg_start) begin
            state     <= LOAD;
            load_cnt  <= (N_IN+1)'(DEPTH);
            cfg_ready <= 1'b1;
          end
        end
        SETTLE_WAIT: begin
          if (settle_cnt == '0) begin
            out_bit   <= tt[vec_q];
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (out_fire && !in_fire) state <= RUN;
        end
        LOAD: begin
          if (cfg_fire) begin
            load_cnt <= load_cnt - 1'b1;
            if (load_cnt == (N_IN+1)'(1)) begin
              tt         <= shadow_next;
              cfg_done   <= 1'b1;
              cfg_ready  <= 1'b0;
              toggle_cnt <= '0;
              prev_bit   <= 1'b0;
              state      <= RUN;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cello_tt_eval_seq.sv
// Randomised bench for cello_tt_eval_seq against a table/counter reference model.
module tb_cello_tt_eval_seq;

  localparam int N_IN   = 4;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;
  localparam logic [15:0] RESET_TT = 16'hB8AD;
  localparam int TMO    = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_start, cfg_valid, cfg_bit;
  logic             cfg_ready, cfg_done;
  logic             in_valid, in_ready;
  logic [N_IN-1:0]  in_vec;
  logic             out_valid, out_ready, out_bit;
  logic [CNT_W-1:0] toggle_cnt;

  // Reference model: active table, last delivered bit, transition count.
  logic [15:0] m_tt;
  logic        m_prev;
  int          m_cnt;

  int n_checks = 0;
  int n_errors = 0;

  cello_tt_eval_seq #(
    .N_IN(N_IN), .RESET_TT(RESET_TT), .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .toggle_cnt(toggle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_deliver(input logic b);
    if (b != m_prev && m_cnt < (2**CNT_W) - 1) m_cnt++;
    m_prev = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_toggle", toggle_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    m_tt = RESET_TT; m_prev = 1'b0; m_cnt = 0;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < TMO) begin tick(); n++; end
    if (n == TMO) check("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < TMO) begin tick(); n++; end
    check(tag, n, SETTLE + 1);
  endtask

  // Accept v, check latency and result, hold for 'hold' cycles, then drain.
  task automatic eval_vec(input logic [N_IN-1:0] v, input int hold);
    logic exp;
    exp = m_tt[v];
    in_valid = 1'b1; in_vec = v;
    wait_in_ready();
    tick();
    in_valid = 1'b0; in_vec = N_IN'($urandom);
    wait_out_valid("latency");
    check("out_bit", out_bit, exp);
    repeat (hold) tick();
    if (hold > 0) check("hold_out_bit", out_bit, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_deliver(exp);
    check("drain_out_valid", out_valid, 0);
  endtask

  // Serial load MSB-first with random gaps; abort_after<16 stops after that many bits.
  task automatic load_tt(input logic [15:0] val, input int abort_after);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("load_cfg_ready", cfg_ready, 1);
    check("load_in_ready", in_ready, 0);
    for (int i = 15; i >= 0; i--) begin
      if (15 - i == abort_after) return;
      repeat ($urandom_range(0, 2)) begin
        cfg_bit = 1'($urandom);
        tick();
        check("gap_cfg_done", cfg_done, 0);
      end
      cfg_valid = 1'b1; cfg_bit = val[i];
      tick();
      cfg_valid = 1'b0; cfg_bit = 1'($urandom);
      check("cfg_done_pulse", cfg_done, (i == 0) ? 1 : 0);
    end
    m_tt = val; m_prev = 1'b0; m_cnt = 0;
    check("commit_toggle", toggle_cnt, 0);
    tick();
    check("cfg_done_clear", cfg_done, 0);
    check("cfg_ready_clear", cfg_ready, 0);
  endtask

  initial begin
    logic exp_a, exp_b;
    logic [N_IN-1:0] v2;
    cfg_bit = 1'b0; in_vec = '0;
    do_reset();

    // 1. Sweep with the reset table.
    for (int v = 0; v < 16; v++) eval_vec(N_IN'(v), 0);
    check("sweep_toggle", toggle_cnt, m_cnt);

    // 2. Back-pressure in HOLD, then drain and accept on the same edge.
    exp_a = m_tt[3];
    in_valid = 1'b1; in_vec = 4'd3;
    wait_in_ready();
    tick();
    in_valid = 1'b0;
    wait_out_valid("bp_latency");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_bit", out_bit, exp_a);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    v2 = N_IN'($urandom);
    exp_b = m_tt[v2];
    in_valid = 1'b1; in_vec = v2; out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    model_deliver(exp_a);
    check("bp_drain_out_valid", out_valid, 0);
    check("bp_settle_in_ready", in_ready, 0);
    wait_out_valid("bp_next_latency");
    check("bp_next_out_bit", out_bit, exp_b);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_deliver(exp_b);
    check("bp_toggle", toggle_cnt, m_cnt);

    // 3. Load 0x0001 with gaps.
    load_tt(16'h0001, 16);
    eval_vec(4'd0, 1);
    eval_vec(4'd7, 0);
    check("ld_toggle", toggle_cnt, m_cnt);

    // 4. Reset partway through a load reverts to the reset table.
    load_tt(16'hFFFF, 9);
    do_reset();
    eval_vec(4'd1, 0);
    check("rst_tt_vec1", m_tt[1], 0);

    // 4b. Reset during the settle window discards the in-flight vector.
    in_valid = 1'b1; in_vec = 4'd0;
    wait_in_ready();
    tick();
    in_valid = 1'b0;
    do_reset();
    repeat (SETTLE + 2) tick();
    check("rst_settle_out_valid", out_valid, 0);

    // 5. Alternate vec0/vec1 until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      eval_vec(N_IN'(i % 2), 0);
      if (i == 100) check("mid_toggle", toggle_cnt, m_cnt);
    end
    check("sat_toggle_model", toggle_cnt, m_cnt);
    check("sat_toggle_255", toggle_cnt, 255);

    // 6. cfg_start while holding a result is ignored.
    exp_a = m_tt[5];
    in_valid = 1'b1; in_vec = 4'd5;
    wait_in_ready();
    tick();
    in_valid = 1'b0;
    wait_out_valid("cs_latency");
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("cs_cfg_ready", cfg_ready, 0);
      check("cs_in_ready", in_ready, 0);
      check("cs_out_bit", out_bit, exp_a);
      check("cs_out_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_deliver(exp_a);
    check("cs_after_cfg_ready", cfg_ready, 0);
    eval_vec(4'd15, 0);

    // Random phase: random tables, vectors and hold times.
    for (int r = 0; r < 6; r++) begin
      load_tt(16'($urandom), 16);
      for (int k = 0; k < 20; k++) eval_vec(N_IN'($urandom), $urandom_range(0, 3));
      check("rand_toggle", toggle_cnt, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
